// File: rtl/race_timer.sv
`default_nettype none
// ============================================================================
// Module      : race_timer
// Description : Race sequencer with a 3-2-1-GO countdown, a BCD m:ss elapsed
//               clock and race end on a finish request or time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module race_timer #(
    parameter int START_COUNT = 3,
    parameter int TIME_LIMIT  = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk1hz,
    input  logic       start,
    input  logic       pause,
    input  logic       finish,
    output logic [1:0] state,
    output logic [3:0] countdown,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       go,
    output logic       timeout,
    output logic       tick
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [3:0] START_CNT_C  = 4'(START_COUNT);
    localparam logic [9:0] TIME_LIMIT_C = 10'(TIME_LIMIT);

    state_t     state_q;
    logic [3:0] countdown_q;
    logic [3:0] min_q, min_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [9:0] elapsed_q, elapsed_d;
    logic       timeout_q;
    logic       clk1hz_q;
    logic       tick_q;
    logic       tick_i;
    logic       carry_ones;
    logic       carry_tens;

    // clk1hz is only ever treated as data; its rising edge becomes an enable.
    assign tick_i = clk1hz & ~clk1hz_q;

    always_comb begin
        carry_ones = (sec_ones_q == 4'd9);
        carry_tens = carry_ones && (sec_tens_q == 4'd5);
        sec_ones_d = carry_ones ? 4'd0 : sec_ones_q + 4'd1;
        sec_tens_d = sec_tens_q;
        if (carry_ones) begin
            sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
        end
        min_d = min_q;
        if (carry_tens && (min_q != 4'd9)) begin
            min_d = min_q + 4'd1;
        end
        elapsed_d = elapsed_q + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            countdown_q <= 4'd0;
            min_q       <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            elapsed_q   <= 10'd0;
            timeout_q   <= 1'b0;
            clk1hz_q    <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            clk1hz_q <= clk1hz;
            tick_q   <= tick_i;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_COUNTDOWN;
                        countdown_q <= START_CNT_C;
                        min_q       <= 4'd0;
                        sec_tens_q  <= 4'd0;
                        sec_ones_q  <= 4'd0;
                        elapsed_q   <= 10'd0;
                        timeout_q   <= 1'b0;
                    end
                end
                S_COUNTDOWN: begin
                    if (tick_i && !pause) begin
                        if (countdown_q == 4'd1) begin
                            state_q     <= S_RUN;
                            countdown_q <= 4'd0;
                        end else begin
                            countdown_q <= countdown_q - 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    // A finish in the same cycle as a tick freezes time before the increment.
                    if (finish) begin
                        state_q   <= S_DONE;
                        timeout_q <= 1'b0;
                    end else if (tick_i && !pause) begin
                        min_q      <= min_d;
                        sec_tens_q <= sec_tens_d;
                        sec_ones_q <= sec_ones_d;
                        elapsed_q  <= elapsed_d;
                        if (elapsed_d == TIME_LIMIT_C) begin
                            state_q   <= S_DONE;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign countdown = countdown_q;
    assign min       = min_q;
    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign go        = (state_q == S_RUN);
    assign timeout   = timeout_q && (state_q == S_DONE);
    assign tick      = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_race_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_timer
// Description : Directed self-checking bench for race_timer (default limit
//               instance plus a 5 s limit instance sharing the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk1hz = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       finish = 1'b0;

    logic [1:0] state, state5;
    logic [3:0] countdown, countdown5;
    logic [3:0] min, min5, sec_tens, sec_tens5, sec_ones, sec_ones5;
    logic       go, go5, timeout, timeout5, tick, tick5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    race_timer dut (
        .clk(clk), .rst(rst), .clk1hz(clk1hz), .start(start), .pause(pause),
        .finish(finish), .state(state), .countdown(countdown), .min(min),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .go(go), .timeout(timeout),
        .tick(tick)
    );

    race_timer #(.START_COUNT(3), .TIME_LIMIT(5)) dut5 (
        .clk(clk), .rst(rst), .clk1hz(clk1hz), .start(start), .pause(pause),
        .finish(finish), .state(state5), .countdown(countdown5), .min(min5),
        .sec_tens(sec_tens5), .sec_ones(sec_ones5), .go(go5), .timeout(timeout5),
        .tick(tick5)
    );

    wire [11:0] t_now  = {min, sec_tens, sec_ones};
    wire [11:0] t5_now = {min5, sec_tens5, sec_ones5};

    // One clk1hz period: two cycles high then two low, inputs changed at negedge.
    task automatic apply_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk1hz = 1'b1;
            @(negedge clk);
            @(negedge clk) clk1hz = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic begin_race();
        clk1hz = 1'b0;
        do_reset();
        pulse_start();
        apply_ticks(3);
    endtask

    task automatic test_reset();
        clk1hz = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_tick cycle %0d got %b want 0", i, tick);
            end
        end
        checks++;
        if ({state, countdown, t_now, go, timeout} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got st=%0d cd=%0d t=%h go=%b to=%b want all 0",
                     state, countdown, t_now, go, timeout);
        end
    endtask

    task automatic test_tick();
        clk1hz = 1'b0;
        @(negedge clk) clk1hz = 1'b1;
        @(negedge clk);
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_pulse got %b want 1", tick);
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_single got %b want 0", tick);
        end
        clk1hz = 1'b0;
    endtask

    task automatic test_countdown();
        clk1hz = 1'b0;
        do_reset();
        pulse_start();
        checks++;
        if (state !== 2'd1 || countdown !== 4'd3) begin
            errors++;
            $display("FAIL cd_start got st=%0d cd=%0d want st=1 cd=3", state, countdown);
        end
        @(negedge clk) finish = 1'b1;
        @(negedge clk) finish = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL cd_ignore_finish got st=%0d want 1", state);
        end
        apply_ticks(1);
        checks++;
        if (countdown !== 4'd2) begin
            errors++;
            $display("FAIL cd_2 got %0d want 2", countdown);
        end
        apply_ticks(1);
        checks++;
        if (countdown !== 4'd1 || go !== 1'b0) begin
            errors++;
            $display("FAIL cd_1 got cd=%0d go=%b want cd=1 go=0", countdown, go);
        end
        @(negedge clk) clk1hz = 1'b1;
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL go_early got %b want 0", go);
        end
        @(posedge clk) #1;
        checks++;
        if (state !== 2'd2 || go !== 1'b1 || countdown !== 4'd0) begin
            errors++;
            $display("FAIL go_timing got st=%0d go=%b cd=%0d want st=2 go=1 cd=0",
                     state, go, countdown);
        end
        @(negedge clk) clk1hz = 1'b0;
    endtask

    task automatic test_bcd_carry();
        begin_race();
        apply_ticks(59);
        checks++;
        if (t_now !== 12'h059) begin
            errors++;
            $display("FAIL bcd_0_59 got %h want 059", t_now);
        end
        apply_ticks(1);
        checks++;
        if (t_now !== 12'h100) begin
            errors++;
            $display("FAIL bcd_1_00 got %h want 100", t_now);
        end
        apply_ticks(60);
        checks++;
        if (t_now !== 12'h200 || state !== 2'd2) begin
            errors++;
            $display("FAIL bcd_2_00 got t=%h st=%0d want t=200 st=2", t_now, state);
        end
        @(negedge clk) clk1hz = 1'b1;
        repeat (100) @(negedge clk);
        clk1hz = 1'b0;
        @(negedge clk);
        checks++;
        if (t_now !== 12'h201) begin
            errors++;
            $display("FAIL long_high got %h want 201", t_now);
        end
    endtask

    task automatic test_time_limit();
        begin_race();
        apply_ticks(4);
        checks++;
        if (state5 !== 2'd2 || t5_now !== 12'h004) begin
            errors++;
            $display("FAIL limit_pre got st=%0d t=%h want st=2 t=004", state5, t5_now);
        end
        apply_ticks(1);
        checks++;
        if (state5 !== 2'd3 || timeout5 !== 1'b1 || t5_now !== 12'h005 || go5 !== 1'b0) begin
            errors++;
            $display("FAIL limit_done got st=%0d to=%b t=%h go=%b want st=3 to=1 t=005 go=0",
                     state5, timeout5, t5_now, go5);
        end
        pause = 1'b1;
        apply_ticks(1);
        pause = 1'b0;
        apply_ticks(1);
        checks++;
        if (state5 !== 2'd3 || t5_now !== 12'h005 || timeout5 !== 1'b1) begin
            errors++;
            $display("FAIL limit_hold got st=%0d t=%h to=%b want st=3 t=005 to=1",
                     state5, t5_now, timeout5);
        end
        pulse_start();
        checks++;
        if (state5 !== 2'd1 || t5_now !== 12'h000 || timeout5 !== 1'b0 || countdown5 !== 4'd3) begin
            errors++;
            $display("FAIL limit_restart got st=%0d t=%h to=%b cd=%0d want st=1 t=000 to=0 cd=3",
                     state5, t5_now, timeout5, countdown5);
        end
    endtask

    task automatic test_pause();
        begin_race();
        apply_ticks(10);
        pause = 1'b1;
        apply_ticks(3);
        checks++;
        if (t_now !== 12'h010 || state !== 2'd2) begin
            errors++;
            $display("FAIL pause_hold got t=%h st=%0d want t=010 st=2", t_now, state);
        end
        pause = 1'b0;
        apply_ticks(1);
        checks++;
        if (t_now !== 12'h011) begin
            errors++;
            $display("FAIL pause_resume got %h want 011", t_now);
        end
    endtask

    task automatic test_finish();
        begin_race();
        apply_ticks(4);
        @(negedge clk) begin
            clk1hz = 1'b1;
            finish = 1'b1;
        end
        @(negedge clk) finish = 1'b0;
        @(negedge clk) clk1hz = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || t_now !== 12'h004 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL finish_tick got st=%0d t=%h to=%b want st=3 t=004 to=0",
                     state, t_now, timeout);
        end
    endtask

    task automatic test_reset_midcount();
        clk1hz = 1'b0;
        do_reset();
        pulse_start();
        apply_ticks(1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (state !== 2'd0 || countdown !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got st=%0d cd=%0d want st=0 cd=0", state, countdown);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick();
        test_countdown();
        test_bcd_carry();
        test_time_limit();
        test_pause();
        test_finish();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
